step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_step_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer
//  Purpose  : Multi-channel drum-machine step sequencer. Each channel owns an
//             active pattern (what is playing) and a staged pattern (a write
//             taken while playing, committed at the next bar boundary or at
//             stop). A tick pulse advances the step while in PLAY.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk_i          system clock, rising edge
//     reset_i        asynchronous active-high reset
//     tick_i         one-cycle step-advance pulse
//     play_i         level: 1 = run, 0 = stop
//     ld_en_i        pattern write strobe
//     ld_ch_i        target channel of the pattern write
//     ld_pattern_i   pattern data, bit k = hit on step k
//     mute_i         per-channel mute, sampled at step entry
//     gate_o         per-channel hit level for the current step
//     trig_o         per-channel one-cycle hit pulse at step entry
//     step_idx_o     current step number
//     bar_strobe_o   pulse on each entry to step 0 while playing
//     running_o      1 while in PLAY
//     pending_o      per-channel staged-write flag
// ============================================================================
module step_sequencer #(
   parameter  int NUM_CH    = 4,
   parameter  int NUM_STEPS = 8,
   localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 tick_i,
   input  logic                 play_i,
   input  logic                 ld_en_i,
   input  logic [CH_W-1:0]      ld_ch_i,
   input  logic [NUM_STEPS-1:0] ld_pattern_i,
   input  logic [NUM_CH-1:0]    mute_i,
   output logic [NUM_CH-1:0]    gate_o,
   output logic [NUM_CH-1:0]    trig_o,
   output logic [STEP_W-1:0]    step_idx_o,
   output logic                 bar_strobe_o,
   output logic                 running_o,
   output logic [NUM_CH-1:0]    pending_o
);

   typedef enum logic [0:0] {
      S_STOP = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   state_t                               state_q, state_d;
   logic [NUM_CH-1:0][NUM_STEPS-1:0]     active_q, active_d;
   logic [NUM_CH-1:0][NUM_STEPS-1:0]     staged_q, staged_d;
   logic [NUM_CH-1:0]                    pending_q, pending_d;
   logic [NUM_CH-1:0]                    gate_q, gate_d;
   logic [NUM_CH-1:0]                    trig_q, trig_d;
   logic [STEP_W-1:0]                    step_q, step_d;
   logic                                 bar_q, bar_d;

   logic                                 ld_ok;
   logic                                 at_last;
   logic [STEP_W-1:0]                    next_step;

   // Out-of-range channel numbers are dropped entirely (only reachable when
   // NUM_CH is not a power of two).
   assign ld_ok     = ld_en_i && ({1'b0, ld_ch_i} < (CH_W + 1)'(NUM_CH));
   assign at_last   = (step_q == LAST_STEP);
   assign next_step = at_last ? '0 : step_q + STEP_W'(1);

   // -------------------------------------------------------------------------
   // State / pattern registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_STOP;
         active_q  <= '0;
         staged_q  <= '0;
         pending_q <= '0;
         gate_q    <= '0;
         trig_q    <= '0;
         step_q    <= '0;
         bar_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         staged_q  <= staged_d;
         pending_q <= pending_d;
         gate_q    <= gate_d;
         trig_q    <= trig_d;
         step_q    <= step_d;
         bar_q     <= bar_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      staged_d  = staged_q;
      pending_d = pending_q;
      gate_d    = gate_q;
      trig_d    = '0;
      step_d    = step_q;
      bar_d     = 1'b0;

      case (state_q)
         S_STOP: begin
            // Nothing is playing, so writes land directly in the active set.
            if (ld_ok) begin
               active_d[ld_ch_i] = ld_pattern_i;
            end
            step_d = '0;
            if (play_i) begin
               state_d = S_PLAY;
               bar_d   = 1'b1;
               for (int c = 0; c < NUM_CH; c++) begin
                  gate_d[c] = active_d[c][0] & ~mute_i[c];
               end
               trig_d = gate_d;
            end else begin
               gate_d = '0;
            end
         end

         S_PLAY: begin
            if (!play_i) begin
               // A write on the stop edge is staged and then committed along
               // with everything else, so nothing staged is ever lost.
               if (ld_ok) begin
                  staged_d[ld_ch_i]  = ld_pattern_i;
                  pending_d[ld_ch_i] = 1'b1;
               end
               for (int c = 0; c < NUM_CH; c++) begin
                  if (pending_d[c]) begin
                     active_d[c] = staged_d[c];
                  end
               end
               pending_d = '0;
               state_d   = S_STOP;
               step_d    = '0;
               gate_d    = '0;
            end else if (tick_i && at_last) begin
               // Bar boundary: commit staged patterns, then let a coincident
               // write override its channel so step 0 already uses it.
               for (int c = 0; c < NUM_CH; c++) begin
                  if (pending_q[c]) begin
                     active_d[c] = staged_q[c];
                  end
               end
               pending_d = '0;
               if (ld_ok) begin
                  active_d[ld_ch_i] = ld_pattern_i;
               end
               step_d = '0;
               bar_d  = 1'b1;
               for (int c = 0; c < NUM_CH; c++) begin
                  gate_d[c] = active_d[c][0] & ~mute_i[c];
               end
               trig_d = gate_d;
            end else begin
               if (ld_ok) begin
                  staged_d[ld_ch_i]  = ld_pattern_i;
                  pending_d[ld_ch_i] = 1'b1;
               end
               if (tick_i) begin
                  step_d = next_step;
                  for (int c = 0; c < NUM_CH; c++) begin
                     gate_d[c] = active_q[c][next_step] & ~mute_i[c];
                  end
                  trig_d = gate_d;
               end
            end
         end

         default: begin
            state_d = S_STOP;
         end
      endcase
   end

   assign gate_o       = gate_q;
   assign trig_o       = trig_q;
   assign step_idx_o   = step_q;
   assign bar_strobe_o = bar_q;
   assign running_o    = (state_q == S_PLAY);
   assign pending_o    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_sequencer
//  Purpose  : Directed self-checking bench for step_sequencer. Three
//             instances: default (4 ch x 8 steps), wide (8 ch x 16 steps) and
//             a 3-channel x 4-step one where an out-of-range channel number
//             is encodable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default instance
   logic       tick, play, ld_en;
   logic [1:0] ld_ch;
   logic [7:0] ld_pat;
   logic [3:0] mute, gate, trig, pend;
   logic [2:0] step;
   logic       bar, run;

   // wide instance
   logic        tick2, play2, ld_en2;
   logic [2:0]  ld_ch2;
   logic [15:0] ld_pat2;
   logic [7:0]  mute2, gate2, trig2, pend2;
   logic [3:0]  step2;
   logic        bar2, run2;

   // 3-channel instance
   logic       tick3, play3, ld_en3;
   logic [1:0] ld_ch3;
   logic [3:0] ld_pat3;
   logic [2:0] mute3, gate3, trig3, pend3;
   logic [1:0] step3;
   logic       bar3, run3;

   int n_checks = 0;
   int n_pass   = 0;

   step_sequencer #(.NUM_CH(4), .NUM_STEPS(8)) dut (
      .clk_i(clk), .reset_i(reset), .tick_i(tick), .play_i(play),
      .ld_en_i(ld_en), .ld_ch_i(ld_ch), .ld_pattern_i(ld_pat), .mute_i(mute),
      .gate_o(gate), .trig_o(trig), .step_idx_o(step), .bar_strobe_o(bar),
      .running_o(run), .pending_o(pend)
   );

   step_sequencer #(.NUM_CH(8), .NUM_STEPS(16)) dut2 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick2), .play_i(play2),
      .ld_en_i(ld_en2), .ld_ch_i(ld_ch2), .ld_pattern_i(ld_pat2), .mute_i(mute2),
      .gate_o(gate2), .trig_o(trig2), .step_idx_o(step2), .bar_strobe_o(bar2),
      .running_o(run2), .pending_o(pend2)
   );

   step_sequencer #(.NUM_CH(3), .NUM_STEPS(4)) dut3 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick3), .play_i(play3),
      .ld_en_i(ld_en3), .ld_ch_i(ld_ch3), .ld_pattern_i(ld_pat3), .mute_i(mute3),
      .gate_o(gate3), .trig_o(trig3), .step_idx_o(step3), .bar_strobe_o(bar3),
      .running_o(run3), .pending_o(pend3)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      tick = 0; play = 0; ld_en = 0; ld_ch = 0; ld_pat = 0; mute = 0;
      tick2 = 0; play2 = 0; ld_en2 = 0; ld_ch2 = 0; ld_pat2 = 0; mute2 = 0;
      tick3 = 0; play3 = 0; ld_en3 = 0; ld_ch3 = 0; ld_pat3 = 0; mute3 = 0;
      repeat (2) cycle();
      n_checks++; if ({gate, trig, pend} !== 12'h000) $display("FAIL reset_vec got=%h exp=000", {gate, trig, pend}); else n_pass++;
      n_checks++; if ({step, bar, run} !== 5'b0) $display("FAIL reset_ctl got=%b exp=00000", {step, bar, run}); else n_pass++;
      n_checks++; if ({gate2, step2, run2} !== 13'h0) $display("FAIL reset_wide got=%h exp=0", {gate2, step2, run2}); else n_pass++;
      n_checks++; if ({gate3, step3, run3} !== 6'h0) $display("FAIL reset_small got=%h exp=0", {gate3, step3, run3}); else n_pass++;
      reset = 1'b0;
      cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_basic_pattern();
      logic [7:0] p0;
      logic [3:0] exp_g;
      int         s;
      p0 = 8'b1000_0101;
      ld_en = 1; ld_ch = 0; ld_pat = p0;
      cycle();
      ld_en = 0;
      n_checks++; if ({pend, gate, run} !== 9'b0) $display("FAIL stop_load got=%b exp=0", {pend, gate, run}); else n_pass++;
      play = 1;
      cycle();
      n_checks++; if ({step, run, bar} !== 5'b000_1_1) $display("FAIL start_ctl got=%b exp=00011", {step, run, bar}); else n_pass++;
      n_checks++; if ({gate, trig} !== 8'b0001_0001) $display("FAIL start_gate got=%b exp=00010001", {gate, trig}); else n_pass++;
      for (int k = 1; k <= 8; k++) begin
         do_tick();
         s = k % 8;
         exp_g = {3'b000, p0[s]};
         n_checks++; if (step !== 3'(s)) $display("FAIL seq_step k=%0d got=%0d exp=%0d", k, step, s); else n_pass++;
         n_checks++; if (gate !== exp_g || trig !== exp_g) $display("FAIL seq_gate k=%0d gate=%b trig=%b exp=%b", k, gate, trig, exp_g); else n_pass++;
         n_checks++; if (bar !== (k == 8)) $display("FAIL seq_bar k=%0d got=%b exp=%b", k, bar, (k == 8)); else n_pass++;
      end
      cycle();
      n_checks++; if ({trig, bar, gate, step} !== 12'b0000_0_0001_000) $display("FAIL hold got=%b exp=000000001000", {trig, bar, gate, step}); else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_staged_load();
      repeat (3) do_tick();
      n_checks++; if (step !== 3'd3) $display("FAIL stage_step got=%0d exp=3", step); else n_pass++;
      ld_en = 1; ld_ch = 1; ld_pat = 8'hFF;
      cycle();
      ld_en = 0;
      n_checks++; if (pend !== 4'b0010 || gate[1] !== 1'b0) $display("FAIL stage_pend pend=%b gate=%b exp pend=0010 gate1=0", pend, gate); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         do_tick();
         n_checks++; if (pend !== 4'b0010 || gate[1] !== 1'b0) $display("FAIL stage_hold k=%0d pend=%b gate=%b", k, pend, gate); else n_pass++;
      end
      do_tick();
      n_checks++; if ({step, bar, pend} !== 8'b000_1_0000) $display("FAIL stage_wrap got=%b exp=00010000", {step, bar, pend}); else n_pass++;
      n_checks++; if (gate !== 4'b0011) $display("FAIL stage_commit gate=%b exp=0011", gate); else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_wrap_load();
      repeat (7) do_tick();
      n_checks++; if (step !== 3'd7) $display("FAIL wl_step got=%0d exp=7", step); else n_pass++;
      tick = 1; ld_en = 1; ld_ch = 2; ld_pat = 8'h01;
      cycle();
      tick = 0; ld_en = 0;
      n_checks++; if ({step, pend} !== 7'b0) $display("FAIL wl_ctl got=%b exp=0", {step, pend}); else n_pass++;
      n_checks++; if (gate !== 4'b0111 || trig !== 4'b0111) $display("FAIL wl_gate gate=%b trig=%b exp=0111", gate, trig); else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_stop_commit();
      ld_en = 1; ld_ch = 3; ld_pat = 8'h0F;
      cycle();
      ld_en = 0;
      n_checks++; if (pend !== 4'b1000) $display("FAIL sc_pend got=%b exp=1000", pend); else n_pass++;
      play = 0;
      cycle();
      n_checks++; if ({run, gate, trig, step, pend, bar} !== 17'b0) $display("FAIL sc_stop got=%b exp=0", {run, gate, trig, step, pend, bar}); else n_pass++;
      do_tick();
      n_checks++; if ({step, gate, run} !== 8'b0) $display("FAIL sc_tick_ignored got=%b exp=0", {step, gate, run}); else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_mute();
      ld_en = 1; ld_ch = 0; ld_pat = 8'hFF;
      cycle();
      ld_en = 0;
      play = 1;
      cycle();
      // ch3 committed at stop (0F) proves the stop-edge commit
      n_checks++; if (gate !== 4'b1111) $display("FAIL mute_start gate=%b exp=1111", gate); else n_pass++;
      repeat (2) do_tick();
      n_checks++; if (gate !== 4'b1011 || step !== 3'd2) $display("FAIL mute_step2 gate=%b step=%0d exp=1011/2", gate, step); else n_pass++;
      mute = 4'b0001;
      cycle();
      n_checks++; if (gate !== 4'b1011 || trig !== 4'b0000) $display("FAIL mute_mid gate=%b trig=%b exp=1011/0000", gate, trig); else n_pass++;
      do_tick();
      n_checks++; if (gate !== 4'b1010 || trig !== 4'b1010) $display("FAIL mute_next gate=%b trig=%b exp=1010", gate, trig); else n_pass++;
      mute = 4'b0000;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid();
      repeat (2) do_tick();
      n_checks++; if (step !== 3'd5) $display("FAIL rm_step got=%0d exp=5", step); else n_pass++;
      reset = 1'b1;
      #2;
      n_checks++; if ({gate, trig, step, run, pend, bar} !== 17'b0) $display("FAIL rm_async got=%b exp=0", {gate, trig, step, run, pend, bar}); else n_pass++;
      cycle();
      n_checks++; if (run !== 1'b0) $display("FAIL rm_held got=%b exp=0", run); else n_pass++;
      reset = 1'b0;
      cycle();
      n_checks++; if ({run, bar, step, gate} !== 9'b1_1_000_0000) $display("FAIL rm_restart got=%b exp=110000000", {run, bar, step, gate}); else n_pass++;
      do_tick();
      n_checks++; if (step !== 3'd1 || gate !== 4'b0000) $display("FAIL rm_cleared step=%0d gate=%b exp=1/0000", step, gate); else n_pass++;
      play = 0;
      cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_wide();
      logic [15:0] p0, p7;
      logic [7:0]  exp_g;
      int          s;
      p0 = 16'h8001;
      p7 = 16'h0100;
      ld_en2 = 1; ld_ch2 = 0; ld_pat2 = p0;
      cycle();
      ld_ch2 = 7; ld_pat2 = p7;
      cycle();
      ld_en2 = 0; play2 = 1;
      cycle();
      n_checks++; if ({gate2, bar2, step2} !== 13'b0000_0001_1_0000) $display("FAIL wide_start got=%b", {gate2, bar2, step2}); else n_pass++;
      for (int k = 1; k <= 16; k++) begin
         tick2 = 1;
         cycle();
         tick2 = 0;
         s = k % 16;
         exp_g = {p7[s], 6'b000000, p0[s]};
         n_checks++; if (step2 !== 4'(s) || bar2 !== (k == 16)) $display("FAIL wide_step k=%0d step=%0d bar=%b exp=%0d/%b", k, step2, bar2, s, (k == 16)); else n_pass++;
         n_checks++; if (gate2 !== exp_g) $display("FAIL wide_gate k=%0d got=%b exp=%b", k, gate2, exp_g); else n_pass++;
      end
      play2 = 0;
      cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_bad_channel_last_wins();
      ld_en3 = 1; ld_ch3 = 2'd3; ld_pat3 = 4'hF;
      cycle();
      ld_en3 = 0; play3 = 1;
      cycle();
      n_checks++; if (gate3 !== 3'b000 || run3 !== 1'b1) $display("FAIL bad_stop gate=%b run=%b exp=000/1", gate3, run3); else n_pass++;
      ld_en3 = 1; ld_ch3 = 2'd3; ld_pat3 = 4'hF;
      cycle();
      n_checks++; if (pend3 !== 3'b000) $display("FAIL bad_play pend=%b exp=000", pend3); else n_pass++;
      ld_ch3 = 2'd1; ld_pat3 = 4'hE;
      cycle();
      ld_pat3 = 4'h1;
      cycle();
      ld_en3 = 0;
      n_checks++; if (pend3 !== 3'b010) $display("FAIL lw_pend got=%b exp=010", pend3); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         tick3 = 1;
         cycle();
         tick3 = 0;
      end
      n_checks++; if ({step3, bar3, pend3} !== 6'b00_1_000) $display("FAIL lw_wrap got=%b exp=001000", {step3, bar3, pend3}); else n_pass++;
      n_checks++; if (gate3 !== 3'b010) $display("FAIL lw_gate got=%b exp=010", gate3); else n_pass++;
      play3 = 0;
      cycle();
   endtask

   initial begin
      test_reset();
      test_basic_pattern();
      test_staged_load();
      test_wrap_load();
      test_stop_commit();
      test_mute();
      test_reset_mid();
      test_wide();
      test_bad_channel_last_wins();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
